fc_sequencer: RTL and testbench
===============================

// Module: fc_sequencer
// PURPOSE
//  Sequencer for the final non-binarized fully-connected classifier stage. Accepts one
//  IC-bit binarized feature vector ({0,1} encodes {-1,+1}), streams Q8.8 weights from an
//  external sync-read weight memory one per cycle, accumulates each class score, and
//  tracks a running argmax. Emits the winning class index and its score to the result sink.
// PARAMETERS
//  IC   288                  input features per class (>=1)
//  OC   10                   output classes (>=1)
//  WAW  $clog2(IC*OC)        weight memory address width
//  CW   max(1,$clog2(OC))    class index width
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      feature vector valid
//  in_ready   out  1      high only in IDLE
//  in_bits    in   IC     feature vector; bit i = feature i (1:+w, 0:-w)
//  w_rd_en    out  1      weight read strobe
//  w_addr     out  WAW    weight address = oc*IC+ic
//  w_data     in   16     signed Q8.8 weight; valid cycle after w_rd_en
//  out_valid  out  1      result valid; held until accepted
//  out_ready  in   1      result sink ready
//  out_class  out  CW     argmax class index
//  out_score  out  16     signed Q8.8 score of out_class
//  busy       out  1      high in RUN or DRAIN
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1, w_rd_en=0, w_addr=0, out_valid=0, out_class=0,
//   out_score=0, busy=0; accumulators/counters cleared. Reset mid-run aborts; read data
//   returning after reset is ignored.
//  FSM IDLE -> RUN on in_valid&&in_ready (edge T); in_bits latched at T.
//  RUN: w_rd_en=1 every cycle; address k (0..IC*OC-1) issued in cycle T+1+k, counters
//   ic/oc advance row-major (ic fastest). After address IC*OC-1 issued -> DRAIN.
//  DRAIN: w_rd_en=0; absorbs final read datum -> DONE.
//  Datapath: registered 1-cycle tag (ic, last-of-class flag, feature bit) travels with
//   each read. On data: acc <= acc + (bit ? w_data : -w_data). On last datum of a class:
//   candidate = that sum; if oc==0 or candidate > best (strictly) -> best<=candidate,
//   best_idx<=oc; acc<=0. Ties keep the lower index.
//  DONE: out_valid=1, out_class/out_score stable; -> IDLE on out_ready (edge); in_ready
//   rises the following cycle. No output change while out_valid&&!out_ready.
//  Latency: out_valid first high in cycle T+IC*OC+2. Throughput: one vector per
//   IC*OC+3 cycles min. in_valid outside IDLE is ignored (in_ready=0).
//  Width: acc, best 16-bit signed Q8.8; compare signed.
// CONFIGURATION
//  FC_SAT_EN defined: each add saturates to [-32768,32767]; negation of -32768 yields
//   +32767. Undefined: two's-complement wrap on every add and negation (-(-32768)=-32768).
// STRUCTURE
//  bnn_pkg: typedef logic signed [15:0] q88_t; Q88_MAX=16'sh7FFF, Q88_MIN=16'sh8000;
//   enum fc_seq_state_e {IDLE,RUN,DRAIN,DONE}.
//  Sub-module fc_sat_acc: combinational acc +/- w step, FC_SAT_EN-aware; shared with any
//   future Q8.8 accumulating layer. Counters, FSM, argmax stay in fc_sequencer.
// TESTING (IC=4, OC=3, 1-cycle sync ROM model unless stated)
//  1 class1 weights all 16'h0100, others 0; in_bits=4'b1111 -> out_class=1,
//    out_score=16'h0400, out_valid first high exactly 14 cycles after accept edge.
//  2 all weights 0, any in_bits -> out_class=0, out_score=0 (tie keeps lowest index).
//  3 in_bits=4'b0000, class2 weights all 16'hFF00, others 16'h0080 -> out_class=2,
//    out_score=16'h0400; w_addr sequence 0..11 one per cycle, contiguous.
//  4 class0 weights all 16'h7000, others 0, in_bits=4'b1111: FC_SAT_EN -> class 0,
//    score 16'h7FFF; without -> class0 wraps to 16'hC000, out_class=1, score 0.
//    Also class0 weight 16'h8000, bit 0: SAT -> +32767 contribution, wrap -> -32768.
//  5 out_ready low 20 cycles in DONE -> out_valid/class/score constant, in_ready=0,
//    w_rd_en=0; out_ready pulse -> out_valid=0 and in_ready=1 next cycle.
//  6 rst pulsed at RUN cycle 5 -> next cycle in_ready=1, w_rd_en=0, out_valid=0,
//    busy=0; subsequent vector of test 1 yields identical result and latency.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types for the binarized-network datapath: Q8.8 scalar type, its limits,
// and the fully-connected sequencer state encoding.
package bnn_pkg;

  typedef logic signed [15:0] q88_t;

  localparam q88_t Q88_MAX = 16'sh7FFF;
  localparam q88_t Q88_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fc_seq_state_e;

endpackage

// File: rtl/fc_sat_acc.sv
// Combinational Q8.8 accumulate step: sum = acc + (pos ? w : -w).
// FC_SAT_EN selects saturating arithmetic; otherwise two's-complement wrap.
module fc_sat_acc
  import bnn_pkg::*;
(
  input  q88_t acc,
  input  q88_t w,
  input  logic pos,
  output q88_t sum
);

`ifdef FC_SAT_EN
  function automatic q88_t sat_neg(input q88_t x);
    return (x == Q88_MIN) ? Q88_MAX : -x;
  endfunction

  function automatic q88_t sat_add(input q88_t a, input q88_t b);
    logic signed [16:0] wide;
    wide = {a[15], a} + {b[15], b};
    if (wide > 17'sd32767)       return Q88_MAX;
    else if (wide < -17'sd32768) return Q88_MIN;
    else                         return wide[15:0];
  endfunction

  q88_t term;
  always_comb begin
    term = pos ? w : sat_neg(w);
    sum  = sat_add(acc, term);
  end
`else
  q88_t term;
  always_comb begin
    term = pos ? w : -w;
    sum  = acc + term;
  end
`endif

endmodule

// File: rtl/fc_sequencer.sv
// Final fully-connected classifier sequencer: streams IC*OC Q8.8 weights, accumulates
// per-class scores and tracks a running argmax. FC_SAT_EN enables saturating adds.
module fc_sequencer
  import bnn_pkg::*;
#(
  parameter int IC  = 288,
  parameter int OC  = 10,
  parameter int WAW = (IC * OC > 1) ? $clog2(IC * OC) : 1,
  parameter int CW  = (OC > 1) ? $clog2(OC) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IC-1:0] in_bits,
  output logic          w_rd_en,
  output logic [WAW-1:0] w_addr,
  input  logic [15:0]   w_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_class,
  output logic [15:0]   out_score,
  output logic          busy
);

  localparam int ICW = (IC > 1) ? $clog2(IC) : 1;
  localparam logic [WAW-1:0] ADDR_LAST = WAW'(IC * OC - 1);
  localparam logic [ICW-1:0] IC_LAST   = ICW'(IC - 1);

  fc_seq_state_e state_q, state_d;

  logic [IC-1:0]  bits_q;
  logic [ICW-1:0] ic_q;
  logic [CW-1:0]  oc_q;
  logic [WAW-1:0] addr_q;
  logic           accept;

  logic           vld_p0;
  logic           last_p0;
  logic           bit_p0;
  logic [CW-1:0]  oc_p0;

  q88_t           acc_q;
  q88_t           best_q;
  logic [CW-1:0]  best_idx_q;
  q88_t           sum_p0;

  assign accept = in_valid && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (addr_q == ADDR_LAST) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign w_rd_en   = (state_q == RUN);
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign out_valid = (state_q == DONE);
  assign w_addr    = addr_q;
  assign out_class = best_idx_q;
  assign out_score = best_q;

  // Address generation: row-major walk, ic fastest.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      addr_q <= '0;
      ic_q   <= '0;
      oc_q   <= '0;
    end else if (state_q == RUN) begin
      addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + WAW'(1);
      if (ic_q == IC_LAST) begin
        ic_q <= '0;
        oc_q <= oc_q + CW'(1);
      end else begin
        ic_q <= ic_q + ICW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) bits_q <= in_bits;
  end

  // Stage p0: tag registered alongside the read, aligned with returning w_data.
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= (state_q == RUN);
  end

  always_ff @(posedge clk) begin
    last_p0 <= (ic_q == IC_LAST);
    bit_p0  <= bits_q[ic_q];
    oc_p0   <= oc_q;
  end

  fc_sat_acc u_acc (
    .acc (acc_q),
    .w   (w_data),
    .pos (bit_p0),
    .sum (sum_p0)
  );

  // Accumulate and argmax; strict compare keeps the lower index on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
    end else if (vld_p0) begin
      if (last_p0) begin
        acc_q <= '0;
        if ((oc_p0 == '0) || (sum_p0 > best_q)) begin
          best_q     <= sum_p0;
          best_idx_q <= oc_p0;
        end
      end else begin
        acc_q <= sum_p0;
      end
    end
  end

endmodule

// File: tb/tb_fc_sequencer.sv
// Scoreboard bench for fc_sequencer at IC=4, OC=3 with a 1-cycle sync weight ROM.
module tb_fc_sequencer;

  localparam int IC = 4;
  localparam int OC = 3;
  localparam int N  = IC * OC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_bits = '0;
  logic        w_rd_en;
  logic [3:0]  w_addr;
  logic [15:0] w_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_class;
  logic [15:0] out_score;
  logic        busy;

  logic signed [15:0] wmem [0:N-1];

  typedef struct {
    int          cls;
    logic [15:0] sc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  fc_sequencer #(.IC(IC), .OC(OC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .w_rd_en   (w_rd_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_rd_en) w_data <= wmem[w_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] a, input logic [15:0] w, input logic p);
    int t, s;
    t = p ? int'($signed(w)) : -int'($signed(w));
`ifdef FC_SAT_EN
    if (t > 32767) t = 32767;
    s = int'($signed(a)) + t;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`else
    s = int'($signed(a)) + t;
`endif
    return s[15:0];
  endfunction

  task automatic ref_model(input logic [3:0] b, output exp_t e);
    logic [15:0] acc;
    e.cls = 0;
    e.sc  = '0;
    for (int o = 0; o < OC; o++) begin
      acc = '0;
      for (int i = 0; i < IC; i++) acc = ref_step(acc, wmem[o*IC+i], b[i]);
      if (o == 0 || $signed(acc) > $signed(e.sc)) begin
        e.cls = o;
        e.sc  = acc;
      end
    end
  endtask

  task automatic load_w(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
    for (int i = 0; i < IC; i++) begin
      wmem[i]        = c0;
      wmem[IC + i]   = c1;
      wmem[2*IC + i] = c2;
    end
  endtask

  task automatic run_vec(input logic [3:0] b, input int hold);
    exp_t e;
    exp_t got;
    int   lat;
    logic [1:0]  cls0;
    logic [15:0] sc0;
    ref_model(b, e);
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    in_bits  = b;
    in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    for (int k = 0; k < N; k++) begin
      check_eq("w_rd_en_run", 32'(w_rd_en), 32'd1);
      check_eq("w_addr_seq", 32'(w_addr), 32'(k));
      @(negedge clk);
      lat++;
    end
    check_eq("drain_rd_en", 32'(w_rd_en), 32'd0);
    check_eq("drain_busy", 32'(busy), 32'd1);
    check_eq("drain_out_valid", 32'(out_valid), 32'd0);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(N + 2));
    check_eq("done_busy", 32'(busy), 32'd0);
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check_eq("out_class", 32'(out_class), 32'(got.cls));
      check_eq("out_score", 32'(out_score), 32'(got.sc));
    end
    cls0 = out_class;
    sc0  = out_score;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_class", 32'(out_class), 32'(cls0));
      check_eq("hold_score", 32'(out_score), 32'(sc0));
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      check_eq("hold_rd_en", 32'(w_rd_en), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("release_valid", 32'(out_valid), 32'd0);
    check_eq("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    load_w(16'h0000, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_rd_en", 32'(w_rd_en), 32'd0);
    check_eq("rst_w_addr", 32'(w_addr), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_class", 32'(out_class), 32'd0);
    check_eq("rst_out_score", 32'(out_score), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    load_w(16'h0000, 16'h0100, 16'h0000);
    run_vec(4'b1111, 0);

    load_w(16'h0000, 16'h0000, 16'h0000);
    run_vec(4'b1010, 0);

    load_w(16'h0080, 16'h0080, 16'hFF00);
    run_vec(4'b0000, 0);

    load_w(16'h7000, 16'h0000, 16'h0000);
    run_vec(4'b1111, 0);

    load_w(16'h0000, 16'h0000, 16'h0000);
    wmem[0] = 16'h8000;
    run_vec(4'b0000, 0);

    load_w(16'h0000, 16'h0100, 16'h0000);
    run_vec(4'b1111, 20);

    // Abort mid-run, then the same vector must behave as a fresh one.
    @(negedge clk);
    in_bits  = 4'b1111;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    check_eq("abort_rd_en", 32'(w_rd_en), 32'd0);
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    run_vec(4'b1111, 0);

    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < N; a++) wmem[a] = 16'($urandom_range(0, 65535));
      run_vec(4'($urandom_range(0, 15)), 2);
    end

    check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
